// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet-locking byte arbiter feeding one UART TX; lock timeout compiled in by UART_TX_ARBITER_TIMEOUT_EN
module uart_tx_arbiter #(
    parameter int NumReq        = 2,
    parameter int LockOnPacket  = 1,
    parameter int TimeoutCycles = 1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [NumReq-1:0]     req_valid_i,
    input  logic [8*NumReq-1:0]   req_data_i,
    input  logic [NumReq-1:0]     req_last_i,
    output logic [NumReq-1:0]     req_ready_o,
    output logic                  tx_valid_o,
    output logic [7:0]            tx_data_o,
    input  logic                  tx_ready_i,
    output logic [NumReq-1:0]     grant_o,
    output logic                  timeout_o
);

    localparam int              IdxW    = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NumReq);
    localparam logic [IdxW-1:0] LastIdx = IdxW'(NumReq - 1);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;

    logic [0:0]      state;
    logic [IdxW-1:0] owner;
    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] pick_idx;
    logic [IdxW-1:0] next_ptr;
    logic [IdxW:0]   cand;
    logic            pick_found;
    logic            locked;
    logic            xfer;
    logic            pkt_done;
    logic            timeout_hit;
    logic            release_now;

    // First valid requester at or after the rotating pointer, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NumReq; i++) begin
            cand = {1'b0, ptr} + (IdxW + 1)'(i);
            if (cand >= NumReqW) begin
                cand = cand - NumReqW;
            end
            if (!pick_found && req_valid_i[cand[IdxW-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
    end

    assign locked = (state == ST_LOCKED);

    always_comb begin
        req_ready_o = '0;
        grant_o     = '0;
        tx_valid_o  = 1'b0;
        tx_data_o   = 8'h00;
        if (locked) begin
            tx_valid_o         = req_valid_i[owner];
            tx_data_o          = req_data_i[{owner, 3'b000} +: 8];
            req_ready_o[owner] = tx_ready_i;
            grant_o[owner]     = 1'b1;
        end
    end

    assign xfer        = tx_valid_o && tx_ready_i;
    assign pkt_done    = xfer && ((LockOnPacket == 0) || req_last_i[owner]);
    assign next_ptr    = (owner == LastIdx) ? '0 : owner + 1'b1;
    assign release_now = pkt_done || timeout_hit;

`ifdef UART_TX_ARBITER_TIMEOUT_EN
    localparam int              CntW    = $clog2(TimeoutCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    logic [CntW-1:0] idle_cnt;

    // Fires on the TimeoutCycles-th consecutive locked cycle without a transfer.
    assign timeout_hit = locked && !xfer && (idle_cnt == CntLast);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idle_cnt  <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_hit;
            if (!locked || xfer || timeout_hit) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign timeout_o   = 1'b0;
`endif

    // Release and grant are separate states, so owners are always split by an idle cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state <= ST_LOCKED;
                        owner <= pick_idx;
                    end
                end
                ST_LOCKED: begin
                    if (release_now) begin
                        state <= ST_IDLE;
                        ptr   <= next_ptr;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter (NumReq=2, TimeoutCycles=16)
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [1:0]  req_valid_i;
    logic [15:0] req_data_i;
    logic [1:0]  req_last_i;
    logic [1:0]  req_ready_o;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic [1:0]  grant_o;
    logic        timeout_o;

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;

    typedef struct packed {
        logic       last;
        logic [7:0] data;
    } beat_t;

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    beat_t src_q0[$];
    beat_t src_q1[$];
    exp_t  exp_q[$];
    beat_t b0;
    beat_t b1;
    exp_t  e_mon;
    logic [1:0] en;
    logic [1:0] acc;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NumReq(2),
        .LockOnPacket(1),
        .TimeoutCycles(16)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_data_i(req_data_i),
        .req_last_i(req_last_i),
        .req_ready_o(req_ready_o),
        .tx_valid_o(tx_valid_o),
        .tx_data_o(tx_data_o),
        .tx_ready_i(tx_ready_i),
        .grant_o(grant_o),
        .timeout_o(timeout_o)
    );

    // Requester model: presents the head of each queue, pops it once accepted.
    always @(posedge clk) begin
        #2;
        if (acc[0] && src_q0.size() != 0) void'(src_q0.pop_front());
        if (acc[1] && src_q1.size() != 0) void'(src_q1.pop_front());
        b0 = (src_q0.size() != 0) ? src_q0[0] : '0;
        b1 = (src_q1.size() != 0) ? src_q1[0] : '0;
        req_valid_i = {en[1] && (src_q1.size() != 0), en[0] && (src_q0.size() != 0)};
        req_data_i  = {b1.data, b0.data};
        req_last_i  = {b1.last, b0.last};
    end

    always @(negedge clk) begin
        acc = req_valid_i & req_ready_o;
        if (!rst_i && tx_valid_o && tx_ready_i) begin
            xfer_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL xfer_unexpected got data=%h grant=%b required no transfer", tx_data_o, grant_o);
            end else begin
                e_mon = exp_q.pop_front();
                if (tx_data_o !== e_mon.data || grant_o !== (2'b01 << e_mon.req)) begin
                    errors++;
                    $display("FAIL xfer_data got data=%h grant=%b required data=%h grant=%b",
                             tx_data_o, grant_o, e_mon.data, 2'b01 << e_mon.req);
                end
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [7:0] d, input logic l);
        beat_t b;
        exp_t  e;
        b.last = l;
        b.data = d;
        e.req  = k;
        e.data = d;
        if (k == 0) src_q0.push_back(b);
        else src_q1.push_back(b);
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({grant_o, req_ready_o, tx_valid_o, timeout_o, tx_data_o} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got grant=%b ready=%b valid=%b to=%b data=%h required all zero",
                     grant_o, req_ready_o, tx_valid_o, timeout_o, tx_data_o);
        end
        step();
        rst_i = 1'b0;
    endtask

    task automatic test_single_packet;
        int start;
        bit ok;
        step();
        start = xfer_cnt;
        push(0, 8'h41, 1'b0);
        push(0, 8'h42, 1'b0);
        push(0, 8'h0A, 1'b1);
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00) begin
            errors++;
            $display("FAIL sp_latency got grant=%b required 00", grant_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== 2'b01 || tx_valid_o !== 1'b1) begin
                errors++;
                $display("FAIL sp_beat%0d got grant=%b valid=%b required 01 1", i, grant_o, tx_valid_o);
            end
        end
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00 || tx_valid_o !== 1'b0 || xfer_cnt - start != 3) begin
            errors++;
            $display("FAIL sp_idle got grant=%b valid=%b xfers=%0d required 00 0 3",
                     grant_o, tx_valid_o, xfer_cnt - start);
        end
        wait_drain(ok);
    endtask

    task automatic test_two_simultaneous;
        logic [1:0] exp_g [7];
        bit ok;
        exp_g = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        step();
        push(0, 8'h10, 1'b0);
        push(0, 8'h11, 1'b1);
        push(1, 8'h20, 1'b0);
        push(1, 8'h21, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== exp_g[i] || (grant_o[0] && req_ready_o[1] !== 1'b0)) begin
                errors++;
                $display("FAIL two_grant_c%0d got grant=%b ready=%b required grant=%b", i, grant_o, req_ready_o, exp_g[i]);
            end
        end
        wait_drain(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL two_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_lock_hold;
        bit ok;
        bit seen0;
        step();
        push(1, 8'h30, 1'b0);
        push(1, 8'h31, 1'b0);
        push(1, 8'h32, 1'b0);
        push(1, 8'h33, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b10) begin
            errors++;
            $display("FAIL lock_grant1 got grant=%b required 10", grant_o);
        end
        step();
        push(0, 8'h3A, 1'b0);
        push(0, 8'h3B, 1'b1);
        seen0 = 1'b0;
        for (int i = 0; i < 20 && !seen0; i++) begin
            @(negedge clk);
            if (grant_o === 2'b01) begin
                seen0 = 1'b1;
            end else begin
                checks++;
                if (req_ready_o[0] !== 1'b0 || req_valid_i[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL lock_wait got ready0=%b valid0=%b required 0 1", req_ready_o[0], req_valid_i[0]);
                end
            end
        end
        checks++;
        if (!seen0) begin
            errors++;
            $display("FAIL lock_regrant got grant=%b required 01 within bound", grant_o);
        end
        wait_drain(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL lock_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int start;
        bit ok;
        step();
        tx_ready_i = 1'b0;
        start = xfer_cnt;
        push(0, 8'h55, 1'b0);
        push(0, 8'h56, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== 8'h55 || req_ready_o !== 2'b00 ||
                grant_o !== 2'b01 || xfer_cnt != start) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b data=%h ready=%b grant=%b required 1 55 00 01",
                         i, tx_valid_o, tx_data_o, req_ready_o, grant_o);
            end
        end
        step();
        tx_ready_i = 1'b1;
        wait_drain(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL bp_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_regrant;
        logic [1:0] exp_g [7];
        exp_g = '{2'b00, 2'b01, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00};
        step();
        push(0, 8'h81, 1'b1);
        push(0, 8'h82, 1'b1);
        push(0, 8'h83, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== exp_g[i]) begin
                errors++;
                $display("FAIL regrant_c%0d got grant=%b required %b", i, grant_o, exp_g[i]);
            end
        end
    endtask

    task automatic test_owner_drop;
        bit ok;
        step();
        push(0, 8'h61, 1'b0);
        push(0, 8'h62, 1'b0);
        push(0, 8'h63, 1'b1);
        @(negedge clk);
        @(negedge clk);
        step();
        en[0] = 1'b0;
`ifdef UART_TX_ARBITER_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== 2'b01 || timeout_o !== 1'b0) begin
                errors++;
                $display("FAIL to_hold%0d got grant=%b to=%b required 01 0", i, grant_o, timeout_o);
            end
        end
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00 || timeout_o !== 1'b1) begin
            errors++;
            $display("FAIL to_release got grant=%b to=%b required 00 1", grant_o, timeout_o);
        end
        @(negedge clk);
        checks++;
        if (timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL to_pulse got to=%b required 0", timeout_o);
        end
        step();
        src_q0.delete();
        exp_q.delete();
        acc = 2'b00;
        en  = 2'b11;
`else
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (grant_o !== 2'b01 || timeout_o !== 1'b0 || tx_valid_o !== 1'b0) begin
                errors++;
                $display("FAIL drop_hold%0d got grant=%b to=%b valid=%b required 01 0 0",
                         i, grant_o, timeout_o, tx_valid_o);
            end
        end
        step();
        en[0] = 1'b1;
        wait_drain(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL drop_drain got pending=%0d required 0", exp_q.size());
        end
`endif
        step();
        push(1, 8'h91, 1'b1);
        push(0, 8'h92, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b10) begin
            errors++;
            $display("FAIL drop_ptr got grant=%b required 10", grant_o);
        end
        wait_drain(ok);
    endtask

    task automatic test_reset_mid_packet;
        bit ok;
        step();
        push(0, 8'hA1, 1'b0);
        push(0, 8'hA2, 1'b0);
        push(0, 8'hA3, 1'b0);
        push(0, 8'hA4, 1'b1);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        step();
        rst_i = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b00 || tx_valid_o !== 1'b0 || req_ready_o !== 2'b00 || timeout_o !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_out got grant=%b valid=%b ready=%b to=%b required 00 0 00 0",
                     grant_o, tx_valid_o, req_ready_o, timeout_o);
        end
        step();
        src_q0.delete();
        exp_q.delete();
        acc = 2'b00;
        step();
        rst_i = 1'b0;
        push(0, 8'hB1, 1'b1);
        push(1, 8'hB2, 1'b1);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (grant_o !== 2'b01) begin
            errors++;
            $display("FAIL rstmid_ptr got grant=%b required 01", grant_o);
        end
        wait_drain(ok);
        checks++;
        if (ok !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_drain got pending=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        tx_ready_i  = 1'b1;
        en          = 2'b11;
        acc         = 2'b00;
        req_valid_i = 2'b00;
        req_data_i  = 16'h0;
        req_last_i  = 2'b00;
        @(posedge clk);
        #1;
        test_reset();
        test_single_packet();
        test_two_simultaneous();
        test_lock_hold();
        test_backpressure();
        test_regrant();
        test_owner_drop();
        test_reset_mid_packet();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got no completion required finish before 200000");
        $fatal(1);
    end

endmodule
